// File: rtl/zeroheti_obi_rr_arbiter_if.sv
// OBI bundle with NumPorts request lanes and one shared response lane.
// The arbiter uses the slave modport toward its managers and the master modport toward the subordinate.
interface zeroheti_obi_rr_arbiter_if #(
    parameter int NumPorts  = 1,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic [NumPorts-1:0]             req;
    logic [NumPorts-1:0]             gnt;
    logic [NumPorts*AddrWidth-1:0]   addr;
    logic [NumPorts-1:0]             we;
    logic [NumPorts*DataWidth/8-1:0] be;
    logic [NumPorts*DataWidth-1:0]   wdata;
    logic [NumPorts-1:0]             rvalid;
    logic [DataWidth-1:0]            rdata;
    logic                            err;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/zeroheti_obi_rr_arbiter.sv
// Round-robin OBI arbiter sharing one subordinate port between NumReq managers, with an in-order ID FIFO for responses.
// Optional ZEROHETI_ARB_DBG_PRIO_EN gives requester 0 (debug SBA) absolute priority whenever no lock is held.
module zeroheti_obi_rr_arbiter #(
    parameter int NumReq         = 3,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    zeroheti_obi_rr_arbiter_if.slave  mgr,
    zeroheti_obi_rr_arbiter_if.master sbr,
    output logic                      busy_o,
    output logic                      protocol_err_o
);
    localparam int BeWidth = DataWidth / 8;
    localparam int IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW    = $clog2(MaxOutstanding + 1);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);

    localparam logic [0:0] StUnlocked = 1'b0;
    localparam logic [0:0] StLocked   = 1'b1;

`ifdef ZEROHETI_ARB_DBG_PRIO_EN
    localparam bit DbgPrio = 1'b1;
`else
    localparam bit DbgPrio = 1'b0;
`endif

    logic [0:0]      state_q, state_d;
    logic [IdxW-1:0] lockIdx_q, lockIdx_d;
    logic [IdxW-1:0] rrPtr_q, rrPtr_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [IdxW-1:0] fifoMem_q [MaxOutstanding];

    logic [IdxW-1:0] rrPick, cand, winner, headId;
    logic            anyReq, fifoFull, fifoEmpty, handshake, pop;

    // Cyclic search for the first active request at or after the round-robin pointer.
    always_comb begin
        rrPick = '0;
        cand   = '0;
        anyReq = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            cand = (int'(rrPtr_q) + k >= NumReq) ? IdxW'(int'(rrPtr_q) + k - NumReq)
                                                 : IdxW'(int'(rrPtr_q) + k);
            if (!anyReq && mgr.req[cand]) begin
                anyReq = 1'b1;
                rrPick = cand;
            end
        end
    end

    always_comb begin
        winner = rrPick;
        if (state_q == StLocked) begin
            winner = lockIdx_q;
        end else if (DbgPrio && mgr.req[0]) begin
            winner = '0;
        end
    end

    assign fifoFull  = (count_q == MaxCnt);
    assign fifoEmpty = (count_q == '0);
    assign sbr.req   = (state_q == StLocked) | (!fifoFull & anyReq);
    assign handshake = sbr.req[0] & sbr.gnt[0];
    assign pop       = sbr.rvalid[0] & !fifoEmpty;
    assign headId    = fifoMem_q[head_q];

    always_comb begin
        mgr.gnt = '0;
        if (handshake) begin
            mgr.gnt[winner] = 1'b1;
        end
    end

    always_comb begin
        sbr.addr  = '0;
        sbr.we    = '0;
        sbr.be    = '0;
        sbr.wdata = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (winner == IdxW'(i)) begin
                sbr.addr  = mgr.addr[i*AddrWidth +: AddrWidth];
                sbr.we[0] = mgr.we[i];
                sbr.be    = mgr.be[i*BeWidth +: BeWidth];
                sbr.wdata = mgr.wdata[i*DataWidth +: DataWidth];
            end
        end
    end

    // Responses are routed combinationally to the oldest outstanding manager; orphans are dropped.
    always_comb begin
        mgr.rvalid = '0;
        if (pop) begin
            mgr.rvalid[headId] = 1'b1;
        end
    end

    assign mgr.rdata      = pop ? sbr.rdata : '0;
    assign mgr.err        = pop & sbr.err;
    assign protocol_err_o = sbr.rvalid[0] & fifoEmpty;
    assign busy_o         = !fifoEmpty | (state_q == StLocked);

    always_comb begin
        state_d   = state_q;
        lockIdx_d = lockIdx_q;
        rrPtr_d   = rrPtr_q;
        if (handshake) begin
            state_d = StUnlocked;
            if (!(DbgPrio && winner == '0)) begin
                rrPtr_d = (winner == LastIdx) ? '0 : winner + 1'b1;
            end
        end else if (sbr.req[0]) begin
            state_d   = StLocked;
            lockIdx_d = winner;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (handshake) begin
            tail_d = (tail_q == LastPtr) ? '0 : tail_q + 1'b1;
        end
        if (pop) begin
            head_d = (head_q == LastPtr) ? '0 : head_q + 1'b1;
        end
        case ({handshake, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StUnlocked;
            lockIdx_q <= '0;
            rrPtr_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            lockIdx_q <= lockIdx_d;
            rrPtr_q   <= rrPtr_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifoMem_q[tail_q] <= winner;
        end
    end

    // A lock is only taken while a slot is free and no push happens until it clears.
    lockHasRoom: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == StLocked) |-> !fifoFull);
endmodule

// File: tb/tb_zeroheti_obi_rr_arbiter.sv
// Self-checking bench for zeroheti_obi_rr_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Honours ZEROHETI_ARB_DBG_PRIO_EN so the same bench covers both builds.
module tb_zeroheti_obi_rr_arbiter;
    localparam int NumReq = 3;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int BW     = DW / 8;
    localparam int MaxOut = 2;
`ifdef ZEROHETI_ARB_DBG_PRIO_EN
    localparam bit DbgPrio = 1'b1;
`else
    localparam bit DbgPrio = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, perr;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: pointer, lock owner and the queue of outstanding requester IDs.
    int rrPtr = 0;
    int lockIdx = 0;
    bit lockM = 1'b0;
    int q[$];

    int                expWin;
    logic              expSreq, expErr, expPerr, expBusy;
    logic [NumReq-1:0] expGnt, expRvalid;
    logic [DW-1:0]     expRdata;
    logic [AW-1:0]     addrA [NumReq];
    logic [DW-1:0]     wdataA [NumReq];
    logic [BW-1:0]     beA [NumReq];
    logic [NumReq-1:0] weV;

    always #5 clk = ~clk;

    zeroheti_obi_rr_arbiter_if #(.NumPorts(NumReq), .AddrWidth(AW), .DataWidth(DW)) mgrIf ();
    zeroheti_obi_rr_arbiter_if #(.NumPorts(1), .AddrWidth(AW), .DataWidth(DW)) sbrIf ();

    zeroheti_obi_rr_arbiter #(
        .NumReq(NumReq), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i(clk), .rst_i(rst), .mgr(mgrIf), .sbr(sbrIf),
        .busy_o(busy), .protocol_err_o(perr)
    );

    task automatic modelEval();
        int n;
        bit found;
        expWin = 0;
        found  = 1'b0;
        if (lockM) begin
            expWin  = lockIdx;
            expSreq = 1'b1;
        end else begin
            if (DbgPrio && mgrIf.req[0]) begin
                expWin = 0;
                found  = 1'b1;
            end else begin
                for (int k = 0; k < NumReq; k++) begin
                    n = (rrPtr + k) % NumReq;
                    if (!found && mgrIf.req[n]) begin
                        expWin = n;
                        found  = 1'b1;
                    end
                end
            end
            expSreq = found && (q.size() < MaxOut);
        end
        expGnt = (expSreq && sbrIf.gnt[0]) ? (NumReq'(1) << expWin) : '0;
        if (sbrIf.rvalid[0] && q.size() > 0) begin
            expRvalid = NumReq'(1) << q[0];
            expRdata  = sbrIf.rdata;
            expErr    = sbrIf.err;
            expPerr   = 1'b0;
        end else begin
            expRvalid = '0;
            expRdata  = '0;
            expErr    = 1'b0;
            expPerr   = sbrIf.rvalid[0];
        end
        expBusy = (q.size() != 0) || lockM;
    endtask

    task automatic modelAdvance();
        if (sbrIf.rvalid[0] && q.size() > 0) q.delete(0);
        if (expSreq && sbrIf.gnt[0]) begin
            q.push_back(expWin);
            lockM = 1'b0;
            if (!(DbgPrio && expWin == 0)) rrPtr = (expWin + 1) % NumReq;
        end else if (expSreq) begin
            lockM   = 1'b1;
            lockIdx = expWin;
        end
        if (rst) begin
            q.delete();
            lockM = 1'b0;
            rrPtr = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NumReq-1:0] req, input logic gnt, input logic rv, input logic err);
        for (int i = 0; i < NumReq; i++) begin
            addrA[i]  = $urandom;
            wdataA[i] = $urandom;
            beA[i]    = BW'($urandom);
            weV[i]    = 1'($urandom);
            mgrIf.addr[i*AW +: AW]  = addrA[i];
            mgrIf.wdata[i*DW +: DW] = wdataA[i];
            mgrIf.be[i*BW +: BW]    = beA[i];
        end
        mgrIf.we        = weV;
        mgrIf.req       = req;
        sbrIf.gnt[0]    = gnt;
        sbrIf.rvalid[0] = rv;
        sbrIf.err       = err;
        sbrIf.rdata     = $urandom;
        modelEval();
        #3;
    endtask

    task automatic doReset();
        rst          = 1'b1;
        mgrIf.req    = '0;
        mgrIf.addr   = '0;
        mgrIf.we     = '0;
        mgrIf.be     = '0;
        mgrIf.wdata  = '0;
        sbrIf.gnt    = '0;
        sbrIf.rvalid = '0;
        sbrIf.rdata  = '0;
        sbrIf.err    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        lockM = 1'b0;
        rrPtr = 0;
    endtask

    task automatic test_reset();
        doReset();
        drive(3'b010, 1'b0, 1'b0, 1'b0);
        modelAdvance();
        doReset();
        drive('0, 1'b0, 1'b0, 1'b0);
        checks++; if (mgrIf.gnt !== '0) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 000", mgrIf.gnt); end
        checks++; if (mgrIf.rvalid !== '0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 000", mgrIf.rvalid); end
        checks++; if (sbrIf.req[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_sbr_req: got %b expected 0", sbrIf.req[0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (perr !== 1'b0 || mgrIf.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got perr=%b err=%b expected 0/0", perr, mgrIf.err); end
        modelAdvance();
    endtask

    task automatic test_round_robin();
        logic [NumReq-1:0] prevGnt = '0;
        int order;
        doReset();
        for (int c = 0; c < 9; c++) begin
            order = DbgPrio ? 0 : c % NumReq;
            drive('1, 1'b1, prevGnt != '0, 1'b0);
            checks++; if (mgrIf.gnt !== (NumReq'(1) << order)) begin errors++; $display("[TB] FAIL rr_gnt cycle %0d: got %b expected %b", c, mgrIf.gnt, NumReq'(1) << order); end
            checks++; if (sbrIf.addr !== addrA[order]) begin errors++; $display("[TB] FAIL rr_addr cycle %0d: got %h expected %h", c, sbrIf.addr, addrA[order]); end
            checks++; if (mgrIf.rvalid !== prevGnt) begin errors++; $display("[TB] FAIL rr_rvalid cycle %0d: got %b expected %b", c, mgrIf.rvalid, prevGnt); end
            prevGnt = NumReq'(1) << order;
            modelAdvance();
        end
        drive('0, 1'b0, 1'b1, 1'b0);
        checks++; if (mgrIf.rvalid !== prevGnt) begin errors++; $display("[TB] FAIL rr_drain: got %b expected %b", mgrIf.rvalid, prevGnt); end
        modelAdvance();
    endtask

    task automatic test_lock();
        logic [NumReq-1:0] reqT [7] = '{3'b010, 3'b010, 3'b010, 3'b110, 3'b110, 3'b100, 3'b000};
        logic              gntT [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic              rvT  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [NumReq-1:0] eGnt [7] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 3'b000};
        logic [NumReq-1:0] eRv  [7] = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b100};
        int                eIdx [7] = '{1, 1, 1, 1, 1, 2, -1};
        doReset();
        for (int c = 0; c < 7; c++) begin
            drive(reqT[c], gntT[c], rvT[c], 1'b0);
            checks++; if (mgrIf.gnt !== eGnt[c]) begin errors++; $display("[TB] FAIL lock_gnt cycle %0d: got %b expected %b", c, mgrIf.gnt, eGnt[c]); end
            checks++; if (mgrIf.rvalid !== eRv[c]) begin errors++; $display("[TB] FAIL lock_rvalid cycle %0d: got %b expected %b", c, mgrIf.rvalid, eRv[c]); end
            if (eIdx[c] >= 0) begin
                checks++; if (sbrIf.req[0] !== 1'b1 || sbrIf.addr !== addrA[eIdx[c]]) begin errors++; $display("[TB] FAIL lock_addr cycle %0d: got req=%b addr=%h expected req=1 addr=%h", c, sbrIf.req[0], sbrIf.addr, addrA[eIdx[c]]); end
            end
            modelAdvance();
        end
    endtask

    task automatic test_fifo_full();
        logic [NumReq-1:0] reqT  [8] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000};
        logic              rvT   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [NumReq-1:0] eGnt  [8] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
        logic [NumReq-1:0] eRv   [8] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b010, 3'b010, 3'b000};
        logic              eSreq [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic              eBusy [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        doReset();
        for (int c = 0; c < 8; c++) begin
            drive(reqT[c], 1'b1, rvT[c], 1'b0);
            checks++; if (mgrIf.gnt !== eGnt[c]) begin errors++; $display("[TB] FAIL full_gnt cycle %0d: got %b expected %b", c, mgrIf.gnt, eGnt[c]); end
            checks++; if (mgrIf.rvalid !== eRv[c]) begin errors++; $display("[TB] FAIL full_rvalid cycle %0d: got %b expected %b", c, mgrIf.rvalid, eRv[c]); end
            checks++; if (sbrIf.req[0] !== eSreq[c]) begin errors++; $display("[TB] FAIL full_sbr_req cycle %0d: got %b expected %b", c, sbrIf.req[0], eSreq[c]); end
            checks++; if (busy !== eBusy[c]) begin errors++; $display("[TB] FAIL full_busy cycle %0d: got %b expected %b", c, busy, eBusy[c]); end
            modelAdvance();
        end
    endtask

    task automatic test_protocol_err();
        doReset();
        drive('0, 1'b0, 1'b1, 1'b0);
        checks++; if (perr !== 1'b1 || mgrIf.rvalid !== '0) begin errors++; $display("[TB] FAIL perr_empty: got perr=%b rvalid=%b expected 1/000", perr, mgrIf.rvalid); end
        modelAdvance();
        drive('0, 1'b0, 1'b0, 1'b0);
        checks++; if (perr !== 1'b0) begin errors++; $display("[TB] FAIL perr_pulse: got %b expected 0", perr); end
        modelAdvance();
        drive(3'b010, 1'b1, 1'b0, 1'b0);
        modelAdvance();
        drive(3'b010, 1'b1, 1'b0, 1'b0);
        checks++; if (mgrIf.gnt !== 3'b010) begin errors++; $display("[TB] FAIL perr_setup_gnt: got %b expected 010", mgrIf.gnt); end
        rst = 1'b1;
        modelAdvance();
        rst = 1'b0;
        drive('0, 1'b0, 1'b1, 1'b0);
        checks++; if (perr !== 1'b1 || mgrIf.rvalid !== '0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL perr_after_reset: got perr=%b rvalid=%b busy=%b expected 1/000/0", perr, mgrIf.rvalid, busy); end
        modelAdvance();
    endtask

    task automatic test_err_response();
        doReset();
        drive(3'b100, 1'b1, 1'b0, 1'b0);
        checks++; if (mgrIf.gnt !== 3'b100) begin errors++; $display("[TB] FAIL err_gnt: got %b expected 100", mgrIf.gnt); end
        modelAdvance();
        drive('0, 1'b0, 1'b1, 1'b1);
        checks++; if (mgrIf.rvalid !== 3'b100 || mgrIf.err !== 1'b1) begin errors++; $display("[TB] FAIL err_resp: got rvalid=%b err=%b expected 100/1", mgrIf.rvalid, mgrIf.err); end
        checks++; if (mgrIf.rdata !== expRdata) begin errors++; $display("[TB] FAIL err_rdata: got %h expected %h", mgrIf.rdata, expRdata); end
        modelAdvance();
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(NumReq'($urandom), 1'($urandom), ($urandom_range(0, 9) < 4), 1'($urandom));
            checks++; if (mgrIf.gnt !== expGnt) begin errors++; $display("[TB] FAIL rand_gnt cycle %0d: got %b expected %b", c, mgrIf.gnt, expGnt); end
            checks++; if (mgrIf.rvalid !== expRvalid) begin errors++; $display("[TB] FAIL rand_rvalid cycle %0d: got %b expected %b", c, mgrIf.rvalid, expRvalid); end
            checks++; if (sbrIf.req[0] !== expSreq) begin errors++; $display("[TB] FAIL rand_sbr_req cycle %0d: got %b expected %b", c, sbrIf.req[0], expSreq); end
            checks++; if (mgrIf.err !== expErr || perr !== expPerr) begin errors++; $display("[TB] FAIL rand_err cycle %0d: got err=%b perr=%b expected %b/%b", c, mgrIf.err, perr, expErr, expPerr); end
            checks++; if (busy !== expBusy) begin errors++; $display("[TB] FAIL rand_busy cycle %0d: got %b expected %b", c, busy, expBusy); end
            if (expSreq) begin
                checks++;
                if (sbrIf.addr !== addrA[expWin] || sbrIf.we[0] !== weV[expWin] || sbrIf.be !== beA[expWin] || sbrIf.wdata !== wdataA[expWin]) begin
                    errors++;
                    $display("[TB] FAIL rand_payload cycle %0d: got %h/%b/%h/%h expected %h/%b/%h/%h", c, sbrIf.addr, sbrIf.we[0], sbrIf.be, sbrIf.wdata, addrA[expWin], weV[expWin], beA[expWin], wdataA[expWin]);
                end
            end
            if (expRvalid != '0) begin
                checks++; if (mgrIf.rdata !== expRdata) begin errors++; $display("[TB] FAIL rand_rdata cycle %0d: got %h expected %h", c, mgrIf.rdata, expRdata); end
            end
            modelAdvance();
            rst = 1'b0;
        end
    endtask

    initial begin
        $display("[TB] starting, DbgPrio=%0d", DbgPrio);
        test_reset();
        test_round_robin();
        test_lock();
        test_fifo_full();
        test_protocol_err();
        test_err_response();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
